// File: rtl/sopc_be_gpio_pkg.sv
// ---------------------------------------------------------------------------
// sopc_be_gpio_pkg
// Shared definitions for the GPIO slave: the word addresses of the register
// map, the encodings of the EDGE_TYPE parameter and a per-bit edge qualifier
// used by the synchroniser.
// ---------------------------------------------------------------------------
package sopc_be_gpio_pkg;

  // Word addresses of the register map. Addresses 6 and 7 are reserved and
  // therefore have no name; they read 0 and ignore writes.
  typedef enum logic [2:0] {
    ADDR_DATA         = 3'd0,
    ADDR_DIRECTION    = 3'd1,
    ADDR_IRQ_MASK     = 3'd2,
    ADDR_EDGE_CAPTURE = 3'd3,
    ADDR_OUTSET       = 3'd4,
    ADDR_OUTCLEAR     = 3'd5
  } gpio_addr_e;

  // Values accepted by the EDGE_TYPE parameter.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Decides whether one bit moving from prev to cur counts as an edge of the
  // requested kind. Unknown encodings fall back to rising-edge behaviour.
  function automatic logic edge_hit(input logic cur, input logic prev, input int edgeType);
    logic hit;
    case (edgeType)
      EDGE_FALLING: hit = ~cur & prev;
      EDGE_ANY:     hit = cur ^ prev;
      default:      hit = cur & ~prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sopc_be_gpio_sync.sv
// ---------------------------------------------------------------------------
// sopc_be_gpio_sync
// Brings the asynchronous pad inputs into the clock domain through a two-flop
// synchroniser, keeps a third flop with the previous synchronised value and
// flags per-bit edges of the kind selected by EDGE_TYPE.
//
// Ports
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset, clears every flop
//   i_pin    asynchronous pad inputs
//   o_sync   synchronised pad value (second synchroniser stage)
//   o_edge   one-cycle edge flags, registered into the capture bits upstream
// ---------------------------------------------------------------------------
module sopc_be_gpio_sync
  import sopc_be_gpio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_fill;
  logic [WIDTH-1:0] w_edge;

  // Synchroniser chain plus the history flop. All three stages clear on
  // reset, so right after release they hold zeros rather than real samples.
  // r_fill walks a 1 along behind the data to mark which stage has received
  // a genuine pin sample since reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_fill <= '0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  // Edge flags compare the current and previous synchronised values. They
  // stay quiet until r_prev holds a real sample; otherwise a pin that simply
  // sits high through reset would look like a 0->1 transition against the
  // cleared flops. Any real toggle after the first post-reset sample still
  // shows up, because that sample is what r_prev ends up comparing against.
  always_comb begin
    w_edge = '0;
    if (r_fill[2]) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_edge[i] = edge_hit(r_sync[i], r_prev[i], EDGE_TYPE);
      end
    end
  end

  assign o_sync = r_sync;
  assign o_edge = w_edge;

endmodule

// File: rtl/sopc_be_gpio_io.sv
// ---------------------------------------------------------------------------
// sopc_be_gpio_io
// Memory-mapped GPIO slave: output data register with atomic set/clear,
// per-bit direction, edge capture with masked level interrupt and a
// registered single-cycle-latency read port.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_address      word register select
//   i_chipselect   slave select
//   i_write_n      active-low write strobe
//   i_read_n       active-low read strobe
//   i_writedata    write data, only the low WIDTH bits are used
//   o_readdata     registered read data, upper bits always 0
//   i_pin_in       asynchronous pad inputs
//   o_out_port     output data register
//   o_oe           per-bit output enable (direction register, 1 = output)
//   o_irq          active-high level interrupt
// ---------------------------------------------------------------------------
module sopc_be_gpio_io
  import sopc_be_gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_address,
  input  logic             i_chipselect,
  input  logic             i_write_n,
  input  logic             i_read_n,
  input  logic [31:0]      i_writedata,
  output logic [31:0]      o_readdata,
  input  logic [WIDTH-1:0] i_pin_in,
  output logic [WIDTH-1:0] o_out_port,
  output logic [WIDTH-1:0] o_oe,
  output logic             o_irq
);

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_wd;
  logic             w_unused_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_cap_clear;
  logic [31:0]      w_rd_value;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_direction;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [31:0]      r_readdata;

  assign w_wr = i_chipselect & ~i_write_n;
  assign w_rd = i_chipselect & ~i_read_n;
  assign w_wd = i_writedata[WIDTH-1:0];

  // Write data above WIDTH-1 is deliberately ignored; folding it into a
  // throwaway net keeps that intent explicit.
  assign w_unused_wd = ^i_writedata;

  // Pad synchronisation and edge detection live in their own block so the
  // register file only ever sees clean, clock-domain signals.
  sopc_be_gpio_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pin   (i_pin_in),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  // Output data, direction and interrupt mask registers. OUTSET and OUTCLEAR
  // give software read-modify-write-free bit manipulation of the outputs.
  // Reset is checked first so it overrides any write in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_out  <= RESET_VALUE;
      r_direction <= '0;
      r_irq_mask  <= '0;
    end else if (w_wr) begin
      case (i_address)
        ADDR_DATA:      r_data_out  <= w_wd;
        ADDR_DIRECTION: r_direction <= w_wd;
        ADDR_IRQ_MASK:  r_irq_mask  <= w_wd;
        ADDR_OUTSET:    r_data_out  <= r_data_out | w_wd;
        ADDR_OUTCLEAR:  r_data_out  <= r_data_out & ~w_wd;
        default:        ;
      endcase
    end
  end

  // Write-one-to-clear mask for the capture register.
  assign w_cap_clear = (w_wr && (i_address == ADDR_EDGE_CAPTURE)) ? w_wd : '0;

  // Capture bits are sticky. The clear is applied before the new edges are
  // OR-ed in, so an edge arriving in the same cycle as its clear survives
  // and no event is lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_edge_capture <= '0;
    end else begin
      r_edge_capture <= (r_edge_capture & ~w_cap_clear) | w_edge;
    end
  end

  // Read mux. It evaluates to zero whenever there is no read strobe, which
  // is what makes readdata drop back to 0 after every non-read cycle.
  // DATA returns the synchronised pins for every bit, whatever the direction.
  always_comb begin
    w_rd_value = '0;
    if (w_rd) begin
      case (i_address)
        ADDR_DATA:         w_rd_value[WIDTH-1:0] = w_sync;
        ADDR_DIRECTION:    w_rd_value[WIDTH-1:0] = r_direction;
        ADDR_IRQ_MASK:     w_rd_value[WIDTH-1:0] = r_irq_mask;
        ADDR_EDGE_CAPTURE: w_rd_value[WIDTH-1:0] = r_edge_capture;
        default:           w_rd_value = '0;
      endcase
    end
  end

  // Registering the mux gives a fixed one-cycle read latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_value;
    end
  end

  assign o_readdata = r_readdata;
  assign o_out_port = r_data_out;
  assign o_oe       = r_direction;

  // Interrupt comes straight from registers, so it is glitch-free.
  assign o_irq = |(r_edge_capture & r_irq_mask);

endmodule
